fetch_stage: RTL and testbench

//  Instruction-fetch stage (stage 1) of the 5-stage RV pipeline; drives decode directly.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_stage.sv | 183 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared constants and types for the 5-stage RV pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned PC_STEP   = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [31:0] instr_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Fetch buffer; circular FIFO with synchronous clear and count.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wptr;
    logic [c_PW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
        return (p == c_PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop  = pop  && (r_count != '0);
    assign w_do_push = push && (r_count != c_CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_do_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            r_count <= r_count + c_CW'(w_do_push) - c_CW'(w_do_pop);
        end
    end

    // Storage needs no reset: only entries below r_count are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push && !clear && !rst) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    assign pop_data = r_mem[r_rptr];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : IF stage: PC, credit-limited imem requests, fetch buffer, IF/ID.
//            Optional FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned       WIDTH      = XLEN,
    parameter logic [WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc,
    output logic [31:0]      instruction,
    output logic             valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_bubbles
`endif
);

    localparam int unsigned      c_CW          = $clog2(FIFO_DEPTH + 1);
    localparam logic [WIDTH-1:0] c_STEP        = WIDTH'(PC_STEP);
    localparam logic [0:0]       c_ST_RUN      = 1'b0;
    localparam logic [0:0]       c_ST_REDIRECT = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [WIDTH-1:0]    r_fetch_pc;
    logic [WIDTH-1:0]    r_resp_pc;
    logic [c_CW-1:0]     r_outstanding;
    logic [c_CW-1:0]     r_discard;
    logic [c_CW-1:0]     w_out_next;
    logic [c_CW-1:0]     w_fifo_count;
    logic [WIDTH+31:0]   w_fifo_rdata;
    logic                w_credit_ok;
    logic                w_issue;
    logic                w_keep;
    logic                w_pop;
    logic [WIDTH-1:0]    r_pc;
    instr_t              r_instr;
    logic                r_valid;

    // Credits cover both words in flight and words already buffered.
    assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_fifo_count})
                         < (c_CW + 1)'(FIFO_DEPTH);
    assign w_issue     = imem_req && imem_ready;
    assign w_keep      = imem_rvalid && !flush && (r_discard == '0);
    assign w_pop       = !stall && !flush && (w_fifo_count != '0);
    assign w_out_next  = r_outstanding + c_CW'(w_issue) - c_CW'(imem_rvalid);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = c_ST_RUN;
        case (r_state)
            c_ST_RUN:      w_state_next = flush ? c_ST_REDIRECT : c_ST_RUN;
            c_ST_REDIRECT: w_state_next = flush ? c_ST_REDIRECT : c_ST_RUN;
            default:       w_state_next = c_ST_RUN;
        endcase
    end

    // FSM: outputs
    always_comb begin
        imem_req = 1'b0;
        if (!rst && !flush && (r_state == c_ST_RUN) && w_credit_ok) begin
            imem_req = 1'b1;
        end
    end

    assign imem_addr = r_fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (flush) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_fetch_pc <= branch_target;
                r_resp_pc  <= branch_target;
                r_discard  <= w_out_next;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + c_STEP;
                end
                if (w_keep) begin
                    r_resp_pc <= r_resp_pc + c_STEP;
                end
                if (imem_rvalid && (r_discard != '0)) begin
                    r_discard <= r_discard - 1'b1;
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (WIDTH + 32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (w_keep),
        .push_data ({r_resp_pc, imem_rdata}),
        .pop       (w_pop),
        .pop_data  (w_fifo_rdata),
        .count     (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!stall) begin
            if (w_pop) begin
                r_pc    <= w_fifo_rdata[WIDTH+31:32];
                r_instr <= w_fifo_rdata[31:0];
                r_valid <= 1'b1;
            end else begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end
        end
    end

    assign pc          = r_pc;
    assign instruction = r_instr;
    assign valid       = r_valid;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;

    // With stall low, IF/ID goes invalid next cycle exactly when nothing is popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_bubbles <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (!stall && !w_pop) begin
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_NOP   = 32'h0000_0013;
    localparam int          c_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .pc            (pc),
        .instruction   (instruction),
        .valid         (valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_bubbles  (perf_bubbles)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state
    logic [31:0] m_fetch_pc, m_resp_pc, m_pc, m_instr;
    bit          m_valid, m_redirect;
    int          m_out, m_disc;
    logic [63:0] m_fifo [$];
    logic [31:0] m_fetched, m_bubbles;

    // Memory model: in-order responses with per-request latency
    logic [31:0] mem_addr_q [$];
    int          mem_due_q  [$];
    int          lat_lo = 1;
    int          lat_hi = 1;

    logic        obs_req, exp_req, obs_valid;
    logic [31:0] obs_addr, exp_addr, obs_pc, obs_instr;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic model_reset();
        m_fetch_pc = 32'h0; m_resp_pc = 32'h0; m_pc = 32'h0; m_instr = c_NOP;
        m_valid = 1'b0; m_redirect = 1'b0; m_out = 0; m_disc = 0;
        m_fifo.delete(); mem_addr_q.delete(); mem_due_q.delete();
        m_fetched = 32'h0; m_bubbles = 32'h0;
    endtask

    // One clock: drive inputs, capture request side, advance model, capture IF/ID.
    task automatic tick(input bit st, input bit fl, input logic [31:0] bt, input bit rdy);
        bit          rv, iss;
        logic [31:0] rd;
        logic [63:0] e;
        @(negedge clk);
        rst = 1'b0; stall = st; flush = fl; branch_target = bt; imem_ready = rdy;
        rv = (mem_due_q.size() > 0) && (mem_due_q[0] <= cyc);
        rd = rv ? word_of(mem_addr_q[0]) : 32'hDEAD_BEEF;
        imem_rvalid = rv; imem_rdata = rd;
        #1;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        exp_req  = !m_redirect && !fl && ((m_out + m_fifo.size()) < c_DEPTH);
        exp_addr = m_fetch_pc;
        iss = exp_req && rdy;
        if (rv) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (iss) begin
            mem_addr_q.push_back(m_fetch_pc);
            mem_due_q.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
        end
        if (fl) begin
            m_out = m_out - int'(rv);
            m_disc = m_out;
            m_fifo.delete();
            m_valid = 1'b0; m_instr = c_NOP;
            m_fetch_pc = bt; m_resp_pc = bt; m_redirect = 1'b1;
            if (!st) m_bubbles++;
        end else begin
            m_redirect = 1'b0;
            if (!st) begin
                if (m_fifo.size() > 0) begin
                    e = m_fifo.pop_front();
                    {m_pc, m_instr} = e;
                    m_valid = 1'b1; m_fetched++;
                end else begin
                    m_valid = 1'b0; m_instr = c_NOP; m_bubbles++;
                end
            end
            if (rv) begin
                m_out--;
                if (m_disc > 0) m_disc--;
                else begin
                    m_fifo.push_back({m_resp_pc, rd});
                    m_resp_pc += 32'd4;
                end
            end
            if (iss) begin
                m_fetch_pc += 32'd4;
                m_out++;
            end
        end
        @(posedge clk);
        #1;
        obs_valid = valid; obs_pc = pc; obs_instr = instruction;
        cyc++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; flush = 1'b1; imem_ready = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; branch_target = 32'h40;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++; $display("FAIL reset_req got %b want 0", imem_req);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({valid, pc, instruction, imem_req} !== {1'b0, 32'h0, c_NOP, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_ifid got v=%b pc=%h ins=%h req=%b want v=0 pc=0 ins=%h req=0",
                     valid, pc, instruction, imem_req, c_NOP);
        end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            n_cmp++;
            if ({obs_req, obs_addr} !== {exp_req, exp_addr}) begin
                n_bad++; $display("FAIL reset_issue cyc=%0d got req=%b addr=%h want req=%b addr=%h",
                                  cyc, obs_req, obs_addr, exp_req, exp_addr);
            end
        end
    endtask

    task automatic test_basic();
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 14; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            n_cmp++;
            if ({obs_req, obs_addr} !== {exp_req, exp_addr}) begin
                n_bad++; $display("FAIL basic_req cyc=%0d got req=%b addr=%h want req=%b addr=%h",
                                  cyc, obs_req, obs_addr, exp_req, exp_addr);
            end
            n_cmp++;
            if ({obs_valid, obs_pc, obs_instr} !== {m_valid, m_pc, m_instr}) begin
                n_bad++; $display("FAIL basic_ifid cyc=%0d got v=%b pc=%h ins=%h want v=%b pc=%h ins=%h",
                                  cyc, obs_valid, obs_pc, obs_instr, m_valid, m_pc, m_instr);
            end
        end
    endtask

    task automatic test_stall();
        logic [64:0] held;
        int          issued;
        lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0, 1'b1);
        held = {obs_valid, obs_pc, obs_instr};
        issued = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 32'h0, 1'b1);
            if (obs_req) issued++;
            n_cmp++;
            if ({obs_valid, obs_pc, obs_instr} !== held) begin
                n_bad++; $display("FAIL stall_hold cyc=%0d got %h want %h",
                                  cyc, {obs_valid, obs_pc, obs_instr}, held);
            end
            n_cmp++;
            if ({obs_req, obs_addr} !== {exp_req, exp_addr}) begin
                n_bad++; $display("FAIL stall_req cyc=%0d got req=%b addr=%h want req=%b addr=%h",
                                  cyc, obs_req, obs_addr, exp_req, exp_addr);
            end
        end
        n_cmp++;
        if (issued > c_DEPTH || obs_req !== 1'b0) begin
            n_bad++; $display("FAIL stall_credit got issued=%0d last_req=%b want issued<=%0d last_req=0",
                              issued, obs_req, c_DEPTH);
        end
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        lat_lo = 4; lat_hi = 4;
        for (int i = 0; i < 10 && m_out < 2; i++) tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b1, 32'h100, 1'b1);
        n_cmp++;
        if ({obs_req, obs_valid, obs_instr} !== {1'b0, 1'b0, c_NOP}) begin
            n_bad++; $display("FAIL flush_now got req=%b v=%b ins=%h want req=0 v=0 ins=%h",
                              obs_req, obs_valid, obs_instr, c_NOP);
        end
        for (int i = 0; i < 30 && !seen; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            n_cmp++;
            if ({obs_req, obs_addr, obs_valid, obs_pc, obs_instr} !==
                {exp_req, exp_addr, m_valid, m_pc, m_instr}) begin
                n_bad++; $display("FAIL flush_seq cyc=%0d got req=%b addr=%h v=%b pc=%h want req=%b addr=%h v=%b pc=%h",
                                  cyc, obs_req, obs_addr, obs_valid, obs_pc, exp_req, exp_addr, m_valid, m_pc);
            end
            if (obs_valid === 1'b1) begin
                seen = 1'b1;
                n_cmp++;
                if ({obs_pc, obs_instr} !== {32'h100, word_of(32'h100)}) begin
                    n_bad++; $display("FAIL flush_first got pc=%h ins=%h want pc=00000100 ins=%h",
                                      obs_pc, obs_instr, word_of(32'h100));
                end
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL flush_timeout got no valid want pc=00000100 within 30 cycles");
        end
    endtask

    task automatic test_flush_stall();
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b1, 1'b1, 32'h200, 1'b1);
        n_cmp++;
        if ({obs_valid, obs_instr} !== {1'b0, c_NOP}) begin
            n_bad++; $display("FAIL flush_stall got v=%b ins=%h want v=0 ins=%h",
                              obs_valid, obs_instr, c_NOP);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            n_cmp++;
            if ({obs_req, obs_addr, obs_valid, obs_pc, obs_instr} !==
                {exp_req, exp_addr, m_valid, m_pc, m_instr}) begin
                n_bad++; $display("FAIL flush_stall_seq cyc=%0d got req=%b addr=%h v=%b pc=%h want req=%b addr=%h v=%b pc=%h",
                                  cyc, obs_req, obs_addr, obs_valid, obs_pc, exp_req, exp_addr, m_valid, m_pc);
            end
        end
    endtask

    task automatic test_ready_low();
        logic [31:0] a0;
        lat_lo = 1; lat_hi = 4;
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        a0 = m_fetch_pc;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b0);
            n_cmp++;
            if (obs_addr !== a0) begin
                n_bad++; $display("FAIL ready_hold cyc=%0d got addr=%h want %h", cyc, obs_addr, a0);
            end
        end
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'($urandom_range(1, 0)));
            n_cmp++;
            if ({obs_req, obs_addr, obs_valid, obs_pc, obs_instr} !==
                {exp_req, exp_addr, m_valid, m_pc, m_instr}) begin
                n_bad++; $display("FAIL ready_seq cyc=%0d got req=%b addr=%h v=%b pc=%h want req=%b addr=%h v=%b pc=%h",
                                  cyc, obs_req, obs_addr, obs_valid, obs_pc, exp_req, exp_addr, m_valid, m_pc);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] bt;
        bit          st, fl, rdy;
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 400; i++) begin
            st  = ($urandom_range(3, 0) == 0);
            fl  = ($urandom_range(29, 0) == 0);
            rdy = ($urandom_range(3, 0) != 0);
            bt  = $urandom() & 32'hFFFF_FFFC;
            tick(st, fl, bt, rdy);
            n_cmp++;
            if ({obs_req, obs_addr, obs_valid, obs_pc, obs_instr} !==
                {exp_req, exp_addr, m_valid, m_pc, m_instr}) begin
                n_bad++; $display("FAIL random_seq cyc=%0d got req=%b addr=%h v=%b pc=%h ins=%h want req=%b addr=%h v=%b pc=%h ins=%h",
                                  cyc, obs_req, obs_addr, obs_valid, obs_pc, obs_instr,
                                  exp_req, exp_addr, m_valid, m_pc, m_instr);
            end
        end
    endtask

    task automatic test_wrap();
        bit          wrapped = 1'b0;
        logic [31:0] last = 32'h1;
        lat_lo = 1; lat_hi = 2;
        tick(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            if (obs_req === 1'b1) begin
                if (last == 32'hFFFF_FFFC && obs_addr === 32'h0) wrapped = 1'b1;
                last = obs_addr;
            end
            n_cmp++;
            if ({obs_req, obs_addr, obs_valid, obs_pc, obs_instr} !==
                {exp_req, exp_addr, m_valid, m_pc, m_instr}) begin
                n_bad++; $display("FAIL wrap_seq cyc=%0d got req=%b addr=%h v=%b pc=%h want req=%b addr=%h v=%b pc=%h",
                                  cyc, obs_req, obs_addr, obs_valid, obs_pc, exp_req, exp_addr, m_valid, m_pc);
            end
        end
        n_cmp++;
        if (!wrapped) begin
            n_bad++; $display("FAIL wrap_addr got no request at 00000000 after FFFFFFFC want wrap");
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        n_cmp++;
        if ({perf_fetched, perf_bubbles} !== {m_fetched, m_bubbles}) begin
            n_bad++; $display("FAIL perf got fetched=%0d bubbles=%0d want fetched=%0d bubbles=%0d",
                              perf_fetched, perf_bubbles, m_fetched, m_bubbles);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; imem_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; branch_target = 32'h0;
        model_reset();
        test_reset();
        test_basic();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        test_stall();
        test_flush();
        test_flush_stall();
        test_ready_low();
        test_random();
        test_wrap();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
